// File: rtl/sound_event_sequencer.sv
// Collision sound sequencer: edge-detects three collision sources, arbitrates them by
// fixed priority and plays one timed note (or a three-note bottom melody) per request.
module sound_event_sequencer #(
   parameter int NOTE_CYCLES = 5_000_000,
   parameter int GAP_CYCLES  = 1_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       brikCollision,
   input  logic       hitBottom,
   input  logic [2:0] batCollision,
   output logic [3:0] toneIndex,
   output logic       soundOn,
   output logic       busy
);
   localparam int MAX_CYCLES = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES);

   localparam logic [CW-1:0] NOTE_LAST  = CW'(NOTE_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
   localparam logic [3:0]    TONE_BRICK = 4'd5;
   localparam logic [3:0]    TONE_BAT   = 4'd8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          mel_q, mel_d;
   logic [1:0]    note_idx_q, note_idx_d;
   logic [3:0]    tone_q, tone_d;
   logic          prev_brick_q, prev_bottom_q, prev_bat_q;
   logic          pend_brick_q, pend_bottom_q, pend_bat_q;
   logic          pend_brick_d, pend_bottom_d, pend_bat_d;

   logic bat_nz;
   logic ev_brick, ev_bottom, ev_bat;
   logic req_brick, req_bottom, req_bat;
   logic arbitrate, start_mel, accept_brick, accept_bat;

   // Melody notes descend 4, 2, 0.
   function automatic logic [3:0] melody_tone(input logic [1:0] idx);
      return 4'd4 - {1'b0, idx, 1'b0};
   endfunction

   assign bat_nz     = |batCollision;
   assign ev_brick   = brikCollision & ~prev_brick_q;
   assign ev_bottom  = hitBottom & ~prev_bottom_q;
   assign ev_bat     = bat_nz & ~prev_bat_q;
   assign req_brick  = pend_brick_q | ev_brick;
   assign req_bottom = pend_bottom_q | ev_bottom;
   assign req_bat    = pend_bat_q | ev_bat;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         mel_q         <= 1'b0;
         note_idx_q    <= 2'd0;
         tone_q        <= 4'd0;
         prev_brick_q  <= 1'b0;
         prev_bottom_q <= 1'b0;
         prev_bat_q    <= 1'b0;
         pend_brick_q  <= 1'b0;
         pend_bottom_q <= 1'b0;
         pend_bat_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         mel_q         <= mel_d;
         note_idx_q    <= note_idx_d;
         tone_q        <= tone_d;
         prev_brick_q  <= brikCollision;
         prev_bottom_q <= hitBottom;
         prev_bat_q    <= bat_nz;
         pend_brick_q  <= pend_brick_d;
         pend_bottom_q <= pend_bottom_d;
         pend_bat_q    <= pend_bat_d;
      end
   end

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      mel_d         = mel_q;
      note_idx_d    = note_idx_q;
      tone_d        = tone_q;
      pend_brick_d  = pend_brick_q | ev_brick;
      pend_bottom_d = pend_bottom_q | ev_bottom;
      pend_bat_d    = pend_bat_q | ev_bat;
      arbitrate     = 1'b0;
      start_mel     = 1'b0;
      accept_brick  = 1'b0;
      accept_bat    = 1'b0;

      unique case (state_q)
         IDLE: arbitrate = 1'b1;
         PLAY: begin
            if (!mel_q && req_bottom) begin
               start_mel = 1'b1;
            end else if (cnt_q == NOTE_LAST) begin
               state_d = GAP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         GAP: begin
            if (!mel_q && req_bottom) begin
               start_mel = 1'b1;
            end else if (cnt_q == GAP_LAST) begin
               if (mel_q && note_idx_q != 2'd2) begin
                  state_d    = PLAY;
                  cnt_d      = '0;
                  note_idx_d = note_idx_q + 2'd1;
                  tone_d     = melody_tone(note_idx_q + 2'd1);
               end else begin
                  mel_d     = 1'b0;
                  arbitrate = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if (arbitrate) begin
         cnt_d = '0;
         if (req_bottom) begin
            start_mel = 1'b1;
         end else if (req_brick) begin
            accept_brick = 1'b1;
            state_d      = PLAY;
            tone_d       = TONE_BRICK;
         end else if (req_bat) begin
            accept_bat = 1'b1;
            state_d    = PLAY;
            tone_d     = TONE_BAT;
         end else begin
            state_d = IDLE;
         end
      end

      // An accepted request is consumed; only a second, fresh event in that cycle re-arms it.
      if (accept_brick) pend_brick_d = pend_brick_q & ev_brick;
      if (accept_bat)   pend_bat_d   = pend_bat_q & ev_bat;

      if (start_mel) begin
         state_d       = PLAY;
         cnt_d         = '0;
         mel_d         = 1'b1;
         note_idx_d    = 2'd0;
         tone_d        = melody_tone(2'd0);
         pend_bottom_d = pend_bottom_q & ev_bottom;
         pend_brick_d  = 1'b0;
         pend_bat_d    = 1'b0;
      end
   end

   always_comb begin
      soundOn   = (state_q == PLAY);
      busy      = (state_q != IDLE);
      toneIndex = tone_q;
   end
endmodule

// File: tb/tb_sound_event_sequencer.sv
// Bench for sound_event_sequencer: spec-derived vector table, a hand-written double melody,
// then random stimulus against a segment-queue reference model.
module tb_sound_event_sequencer;
   localparam int NOTE = 8;
   localparam int GAP  = 4;

   logic       clk = 1'b0;
   logic       reset, brik, hit;
   logic [2:0] bat;
   logic [3:0] toneIndex;
   logic       soundOn, busy;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sound_event_sequencer #(.NOTE_CYCLES(NOTE), .GAP_CYCLES(GAP)) dut (
      .clk          (clk),
      .reset        (reset),
      .brikCollision(brik),
      .hitBottom    (hit),
      .batCollision (bat),
      .toneIndex    (toneIndex),
      .soundOn      (soundOn),
      .busy         (busy)
   );

   typedef struct {
      bit         rst;
      bit         b;
      bit         h;
      logic [2:0] t;
      int         cycles;
      logic [3:0] tone;
      bit         on;
      bit         bsy;
      bit         chk_tone;
   } vec_t;

   vec_t vecs[$];

   // Reference model: the active job is a queue of timed segments.
   typedef struct {
      logic [3:0] tone;
      bit         on;
      int         len;
   } seg_t;

   seg_t       m_q[$];
   bit         m_mel, m_pb, m_ph, m_pt, m_prb, m_prh, m_prt;
   logic [3:0] m_tone;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic add(input bit r, input bit b, input bit h, input logic [2:0] t, input int cyc,
                      input logic [3:0] tone, input bit on, input bit bsy);
      vecs.push_back('{r, b, h, t, cyc, tone, on, bsy, bsy || r});
   endtask

   task automatic drive(input bit r, input bit b, input bit h, input logic [2:0] t);
      reset = r;
      brik  = b;
      hit   = h;
      bat   = t;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_note(input logic [3:0] tone);
      m_q.push_back('{tone, 1'b1, NOTE});
      m_q.push_back('{tone, 1'b0, GAP});
   endtask

   task automatic model_step(input bit r, input bit b, input bit h, input logic [2:0] t);
      bit   eb, eh, et, rb, rh, rt, active, acc_b, acc_t, start;
      seg_t s;
      if (r) begin
         m_q.delete();
         {m_mel, m_pb, m_ph, m_pt, m_prb, m_prh, m_prt} = '0;
         m_tone = 4'd0;
         return;
      end
      eb = b && !m_prb;
      eh = h && !m_prh;
      et = (t != 3'd0) && !m_prt;
      m_prb = b;
      m_prh = h;
      m_prt = (t != 3'd0);
      rb = m_pb || eb;
      rh = m_ph || eh;
      rt = m_pt || et;
      active = (m_q.size() != 0);
      acc_b = 0;
      acc_t = 0;
      start = 0;
      if (active && !m_mel && rh) begin
         start = 1;
      end else begin
         if (active) begin
            s = m_q.pop_front();
            s.len = s.len - 1;
            if (s.len > 0) m_q.push_front(s);
         end
         if (m_q.size() == 0) begin
            if (active) m_mel = 0;
            if (rh) start = 1;
            else if (rb) begin acc_b = 1; load_note(4'd5); end
            else if (rt) begin acc_t = 1; load_note(4'd8); end
         end
      end
      m_pb = acc_b ? (m_pb && eb) : rb;
      m_pt = acc_t ? (m_pt && et) : rt;
      m_ph = start ? (m_ph && eh) : rh;
      if (start) begin
         m_q.delete();
         for (int n = 0; n < 3; n++) load_note(4'(4 - 2 * n));
         m_mel = 1;
         m_pb  = 0;
         m_pt  = 0;
      end
      if (m_q.size() != 0) m_tone = m_q[0].tone;
   endtask

   initial begin
      drive(1, 0, 0, 3'd0);

      // Brick held 3 cycles: one note only.
      add(1, 0, 0, 3'd0, 1, 4'd0, 0, 0);
      add(0, 1, 0, 3'd0, 3, 4'd5, 1, 1);
      add(0, 0, 0, 3'd0, 5, 4'd5, 1, 1);
      add(0, 0, 0, 3'd0, 4, 4'd5, 0, 1);
      add(0, 0, 0, 3'd0, 2, 4'd0, 0, 0);
      // Brick and bat together: back-to-back notes.
      add(0, 1, 0, 3'b010, 1, 4'd5, 1, 1);
      add(0, 0, 0, 3'd0, 7, 4'd5, 1, 1);
      add(0, 0, 0, 3'd0, 4, 4'd5, 0, 1);
      add(0, 0, 0, 3'd0, 8, 4'd8, 1, 1);
      add(0, 0, 0, 3'd0, 4, 4'd8, 0, 1);
      add(0, 0, 0, 3'd0, 2, 4'd0, 0, 0);
      // Bat note pre-empted by bottom after 3 cycles.
      add(0, 0, 0, 3'b001, 1, 4'd8, 1, 1);
      add(0, 0, 0, 3'd0, 2, 4'd8, 1, 1);
      add(0, 0, 1, 3'd0, 1, 4'd4, 1, 1);
      add(0, 0, 0, 3'd0, 7, 4'd4, 1, 1);
      add(0, 0, 0, 3'd0, 4, 4'd4, 0, 1);
      add(0, 0, 0, 3'd0, 8, 4'd2, 1, 1);
      add(0, 0, 0, 3'd0, 4, 4'd2, 0, 1);
      add(0, 0, 0, 3'd0, 8, 4'd0, 1, 1);
      add(0, 0, 0, 3'd0, 4, 4'd0, 0, 1);
      add(0, 0, 0, 3'd0, 2, 4'd0, 0, 0);
      // Bottom+brick together discards brick; later brick served after melody.
      add(0, 1, 1, 3'd0, 1, 4'd4, 1, 1);
      add(0, 0, 0, 3'd0, 7, 4'd4, 1, 1);
      add(0, 0, 0, 3'd0, 4, 4'd4, 0, 1);
      add(0, 1, 0, 3'd0, 1, 4'd2, 1, 1);
      add(0, 0, 0, 3'd0, 7, 4'd2, 1, 1);
      add(0, 0, 0, 3'd0, 4, 4'd2, 0, 1);
      add(0, 0, 0, 3'd0, 8, 4'd0, 1, 1);
      add(0, 0, 0, 3'd0, 4, 4'd0, 0, 1);
      add(0, 0, 0, 3'd0, 8, 4'd5, 1, 1);
      add(0, 0, 0, 3'd0, 4, 4'd5, 0, 1);
      add(0, 0, 0, 3'd0, 2, 4'd0, 0, 0);
      // Reset during melody note 2, then a fresh brick.
      add(0, 0, 1, 3'd0, 1, 4'd4, 1, 1);
      add(0, 0, 0, 3'd0, 7, 4'd4, 1, 1);
      add(0, 0, 0, 3'd0, 4, 4'd4, 0, 1);
      add(0, 0, 0, 3'd0, 3, 4'd2, 1, 1);
      add(1, 0, 0, 3'd0, 1, 4'd0, 0, 0);
      add(0, 1, 0, 3'd0, 1, 4'd5, 1, 1);
      add(0, 0, 0, 3'd0, 7, 4'd5, 1, 1);
      add(0, 0, 0, 3'd0, 4, 4'd5, 0, 1);
      add(0, 0, 0, 3'd0, 1, 4'd0, 0, 0);
      // Three brick pulses during a brick note coalesce into one extra note.
      add(0, 1, 0, 3'd0, 1, 4'd5, 1, 1);
      add(0, 0, 0, 3'd0, 1, 4'd5, 1, 1);
      add(0, 1, 0, 3'd0, 1, 4'd5, 1, 1);
      add(0, 0, 0, 3'd0, 1, 4'd5, 1, 1);
      add(0, 1, 0, 3'd0, 1, 4'd5, 1, 1);
      add(0, 0, 0, 3'd0, 3, 4'd5, 1, 1);
      add(0, 0, 0, 3'd0, 4, 4'd5, 0, 1);
      add(0, 0, 0, 3'd0, 8, 4'd5, 1, 1);
      add(0, 0, 0, 3'd0, 4, 4'd5, 0, 1);
      add(0, 0, 0, 3'd0, 3, 4'd0, 0, 0);
      // Level high through reset counts as one event; holding it does not retrigger.
      add(1, 1, 0, 3'd0, 1, 4'd0, 0, 0);
      add(0, 1, 0, 3'd0, 8, 4'd5, 1, 1);
      add(0, 1, 0, 3'd0, 4, 4'd5, 0, 1);
      add(0, 1, 0, 3'd0, 2, 4'd0, 0, 0);
      add(0, 0, 0, 3'd0, 1, 4'd0, 0, 0);

      foreach (vecs[i]) begin
         for (int c = 0; c < vecs[i].cycles; c++) begin
            drive(vecs[i].rst, vecs[i].b, vecs[i].h, vecs[i].t);
            tick();
            check($sformatf("vec%0d.%0d soundOn", i, c), 32'(soundOn), 32'(vecs[i].on));
            check($sformatf("vec%0d.%0d busy", i, c), 32'(busy), 32'(vecs[i].bsy));
            if (vecs[i].chk_tone)
               check($sformatf("vec%0d.%0d toneIndex", i, c), 32'(toneIndex), 32'(vecs[i].tone));
         end
      end

      // Bottom event during a melody queues a second melody straight after the first.
      for (int m = 0; m < 2; m++)
         for (int n = 0; n < 3; n++)
            for (int c = 0; c < NOTE + GAP; c++) begin
               drive(0, 0, (m == 0 && n == 0 && (c == 0 || c == 4)), 3'd0);
               tick();
               check($sformatf("mel%0d.%0d.%0d soundOn", m, n, c), 32'(soundOn), 32'(c < NOTE));
               check($sformatf("mel%0d.%0d.%0d busy", m, n, c), 32'(busy), 32'd1);
               check($sformatf("mel%0d.%0d.%0d toneIndex", m, n, c), 32'(toneIndex), 32'(4 - 2 * n));
            end
      drive(0, 0, 0, 3'd0);
      tick();
      check("mel_end busy", 32'(busy), 32'd0);

      // Random stimulus against the reference model.
      begin
         bit         r, b, h;
         logic [2:0] t;
         bit         exp_busy, exp_on;
         r = 1; b = 0; h = 0; t = 3'd0;
         for (int k = 0; k < 3000; k++) begin
            if (k > 0) begin
               r = ($urandom_range(0, 299) == 0);
               if ($urandom_range(0, 7) == 0) b = !b;
               if ($urandom_range(0, 59) == 0) h = !h;
               if ($urandom_range(0, 9) == 0)
                  t = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            end
            drive(r, b, h, t);
            model_step(r, b, h, t);
            tick();
            exp_busy = (m_q.size() != 0);
            exp_on   = exp_busy ? m_q[0].on : 1'b0;
            check($sformatf("rnd%0d soundOn", k), 32'(soundOn), 32'(exp_on));
            check($sformatf("rnd%0d busy", k), 32'(busy), 32'(exp_busy));
            if (exp_busy || r)
               check($sformatf("rnd%0d toneIndex", k), 32'(toneIndex), 32'(m_tone));
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/sound_event_sequencer.md
# sound_event_sequencer

Sequences the game's collision sound effects into the tone prescaler lookup. The block edge-detects the three collision sources and holds one pending request per source. It arbitrates the requests by fixed priority and drives a tone index plus a sound-enable for a fixed note duration, followed by a silent gap. A bottom hit plays a three-note descending melody that pre-empts anything else. The block sits between the collision logic and the tone-index input of the prescaler table; soundOn gates the audio output.

## Interface
- NOTE_CYCLES, 5_000_000: clk cycles a note sounds (100 ms @ 50 MHz); must be ≥ 2.
- GAP_CYCLES, 1_000_000: clk cycles of silence after every note; must be ≥ 1.
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- brikCollision  in  1  level; brick hit.
- hitBottom  in  1  level; ball reached the bottom.
- batCollision  in  3  level; non-zero means bat hit.
- toneIndex  out  4  index into the prescaler table (0..11).
- soundOn  out  1  high while a note is sounding.
- busy  out  1  high when the state is not IDLE.

## Operation
- Edge detect:
  - Each source has a prev register: brick, bottom, and batNZ = (batCollision != 0).
  - An event fires when the level is 1 and prev is 0.
  - prev resets to 0, so an input already high on the first cycle after reset counts as an event.
- Pending flags:
  - One flag per source: pB (brick), pH (bottom), pT (bat).
  - An event sets its flag. Repeated events before service coalesce into one.
  - The flag clears on the cycle the request is accepted.
  - An event on the same cycle as acceptance of that source sets the flag again.
- Request = pending flag OR event in the current cycle.
- Priority: bottom > brick > bat.
- Tones:
  - brick = 5.
  - bat = 8.
  - bottom melody = 4, 2, 0 (noteIdx 0..2).
- FSM states: IDLE, PLAY, GAP. Counter cnt; melody flag mel; 2-bit noteIdx.
  - IDLE, any request: go to PLAY with the winner's tone and cnt = 0. A bottom winner sets mel = 1 and noteIdx = 0.
  - PLAY: soundOn = 1. When cnt = NOTE_CYCLES−1, go to GAP with cnt = 0.
  - GAP: soundOn = 0 and toneIndex holds. When cnt = GAP_CYCLES−1:
    - if mel and noteIdx < 2: noteIdx + 1, go to PLAY;
    - else if mel and noteIdx = 2: clear mel, then arbitrate;
    - else: arbitrate. A request goes to PLAY directly with no IDLE cycle; no request goes to IDLE.
- Pre-emption:
  - A bottom request during PLAY or GAP of a non-melody note aborts that note. The next cycle is PLAY with tone 4, mel = 1, cnt = 0.
  - Nothing pre-empts the melody.
  - A bottom event during the melody sets pH, which is served after the melody ends.
- Melody start clears pB and pT, including events in the same cycle.
- Brick and bat requests never abort a note; they wait as pending.
- Counter width is $clog2(max(NOTE_CYCLES, GAP_CYCLES)). Never compare against an out-of-range value.

## Timing
- Reset values: toneIndex = 0, soundOn = 0, busy = 0, state = IDLE, cnt = 0, mel = 0, noteIdx = 0, all pending and prev registers = 0.
- Reset asserted mid-note returns to the reset values on the next edge; pending requests are lost.
- Latency: an event sampled at edge k in IDLE gives soundOn = 1, correct toneIndex and busy = 1 after edge k.
- A note gives soundOn high for exactly NOTE_CYCLES cycles, then low for exactly GAP_CYCLES cycles.
- A full melody gives 3·(NOTE_CYCLES+GAP_CYCLES) busy cycles.
- Back-to-back service: no idle cycle between a GAP end and the next PLAY.
- Simultaneous events in IDLE: the highest priority plays; the others stay pending, except that a melody start discards them.
- A level held high produces one event only; it must drop for at least one cycle to retrigger.

## Test plan
All scenarios use NOTE_CYCLES = 8 and GAP_CYCLES = 4.
- Reset, then brikCollision held high 3 cycles → toneIndex = 5 and soundOn = 1 for 8 cycles, then 0 for 4 cycles, then busy = 0. Only one note plays.
- brikCollision and batCollision = 3'b010 rise on the same cycle → note 5 (12 cycles), then note 8 immediately following, with no IDLE cycle between them.
- batCollision pulse, then hitBottom pulse 3 cycles into PLAY → the tone-8 note is cut off after 3 cycles. The next cycle gives tone 4, then 2, then 0, each sounding 8 cycles with a 4-cycle gap. busy stays high 36 cycles.
- hitBottom and brick pulse together, then a brick pulse during the melody → the melody plays. Both brick requests are discarded if they arrive before or with the melody start; a later one is served after the melody.
- Reset asserted during melody note 2 → the next cycle shows soundOn = 0, toneIndex = 0, busy = 0. A fresh brick pulse afterwards plays normally.
- Three brick pulses (separated by low cycles) during one brick note → exactly one extra note follows.
